ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32 pipeline, directly upstream of mem_stage.
- Consumes the id_ex_t bundle and computes the ALU result, branch/jump redirect and store data.
- Owns the EX/MEM pipeline register and drives the registered ex_mem_t bundle into mem_stage.
- Contains an iterative 32-cycle divider (RV32M DIV/DIVU/REM/REMU) that stalls the front of the pipeline while busy.

---
 rtl/core_pkg.sv | 65 ++++++
 rtl/ex_divider.sv | 141 ++++++++++++++
 rtl/ex_stage.sv | 135 +++++++++++++
 tb/tb_ex_stage.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: types shared by the ID/EX/MEM pipeline stages.
//   id_ex_t       - decoded instruction presented to the execute stage
//   ex_mem_t      - registered execute result presented to mem_stage
//   alu_op_e      - alucontrol encodings (ALU ops plus RV32M divide ops)
//   RES_*         - resultsrc encodings
//   EX_MEM_BUBBLE - all-zero EX/MEM bundle (no writeback, no store)
package core_pkg;

  localparam int CORE_XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLT  = 5'd5,
    ALU_SLTU = 5'd6,
    ALU_SLL  = 5'd7,
    ALU_SRL  = 5'd8,
    ALU_SRA  = 5'd9,
    ALU_DIV  = 5'd16,
    ALU_DIVU = 5'd17,
    ALU_REM  = 5'd18,
    ALU_REMU = 5'd19
  } alu_op_e;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic [CORE_XLEN-1:0] rd1;
    logic [CORE_XLEN-1:0] rd2;
    logic [CORE_XLEN-1:0] immext;
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_XLEN-1:0] pcplus4;
    logic [4:0]           rd;
    alu_op_e              alucontrol;
    logic                 alusrc;
    logic                 regwrite;
    logic [1:0]           resultsrc;
    logic                 memwrite;
    logic                 branch;
    logic                 jump;
  } id_ex_t;

  typedef struct packed {
    logic [CORE_XLEN-1:0] aluresult;
    logic [CORE_XLEN-1:0] writedata;
    logic [4:0]           rd;
    logic [CORE_XLEN-1:0] pcplus4;
    logic                 regwrite;
    logic [1:0]           resultsrc;
    logic                 memwrite;
  } ex_mem_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '0;

  function automatic logic is_div_op(alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_divider.sv
// ex_divider: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; signed operands are divided as magnitudes and
// the result signs re-applied at the end.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             divide op present, valid and not flushed
//   flush             abort the operation in flight
//   op                which divide op (sampled with start)
//   dividend, divisor raw operands (sampled with start)
//   stall             hold upstream (issue cycle and all BUSY cycles)
//   idle, done        FSM state flags
//   result            final quotient/remainder, meaningful while done=1
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a divide op; start captures operands
// BUSY  | one restoring iteration per cycle, cnt 0..DIV_CYCLES-1
// DONE  | result valid for one cycle, written into EX/MEM on exit
module ex_divider
  import core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            stall,
  output logic            idle,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo, rem, dsr, dvd_orig;
  logic            neg_q, neg_r, div0, is_rem;
  logic            last;

  assign last = (cnt == CW'(DIV_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_BUSY;
      S_BUSY: begin
        if (flush)     state_nxt = S_IDLE;
        else if (last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    idle  = (state == S_IDLE);
    done  = (state == S_DONE);
    stall = (state == S_BUSY) || ((state == S_IDLE) && start);
  end

  // Operand preparation for the issue edge.
  logic            sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    sgn   = (op == ALU_DIV) || (op == ALU_REM);
    a_neg = sgn & dividend[XLEN-1];
    b_neg = sgn & divisor[XLEN-1];
    a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag = b_neg ? (~divisor + 1'b1) : divisor;
  end

  // Restoring step: the quotient register doubles as the dividend shifter.
  // A plain compare (not a borrow bit) is used so a zero divisor behaves.
  logic [XLEN:0]   r_shift;
  logic            ge;
  logic [XLEN-1:0] rem_nxt, quo_nxt;

  always_comb begin
    r_shift = {rem, quo[XLEN-1]};
    ge      = (r_shift >= {1'b0, dsr});
    rem_nxt = ge ? (r_shift[XLEN-1:0] - dsr) : r_shift[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dsr      <= '0;
      dvd_orig <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
      is_rem   <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      cnt      <= '0;
      quo      <= a_mag;
      rem      <= '0;
      dsr      <= b_mag;
      dvd_orig <= dividend;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div0     <= (divisor == '0);
      is_rem   <= (op == ALU_REM) || (op == ALU_REMU);
    end else if (state == S_BUSY) begin
      cnt <= cnt + 1'b1;
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

  // 0x80000000 / -1 needs no special case: |q| = 0x80000000 and the
  // negation of that value is itself, remainder magnitude is 0.
  logic [XLEN-1:0] q_fin, r_fin;

  always_comb begin
    q_fin = neg_q ? (~quo + 1'b1) : quo;
    r_fin = neg_r ? (~rem + 1'b1) : rem;
    if (div0) begin
      q_fin = '1;
      r_fin = dvd_orig;
    end
    result = is_rem ? r_fin : q_fin;
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the RV32 pipeline, feeding mem_stage.
// ALU, branch/jump redirect, store data and the EX/MEM pipeline register.
// Optional macro RISCV_EX_DIV_EN: builds the iterative divider; without it
// divide ops complete in one cycle with aluresult=0 and stall is tied low.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   in        decoded instruction (operands already forwarded)
//   flush     squash the instruction in EX
//   out       registered EX/MEM bundle
//   stall     hold IF/ID/ID-EX while high
//   pcsrc     redirect fetch this cycle
//   pctarget  redirect address (pc + immext)
module ex_stage
  import core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  id_ex_t          in,
  input  logic            flush,
  output ex_mem_t         out,
  output logic            stall,
  output logic            pcsrc,
  output logic [XLEN-1:0] pctarget
);

  if (XLEN != 32 || DIV_CYCLES != XLEN) begin : g_bad_cfg
    $error("ex_stage supports only XLEN = DIV_CYCLES = 32");
  end

  logic [XLEN-1:0] srcb, aluresult;
  logic [4:0]      shamt;
  logic            zero;

  assign srcb  = in.alusrc ? in.immext : in.rd2;
  assign shamt = srcb[4:0];

  always_comb begin
    aluresult = '0;
    case (in.alucontrol)
      ALU_ADD:  aluresult = in.rd1 + srcb;
      ALU_SUB:  aluresult = in.rd1 - srcb;
      ALU_AND:  aluresult = in.rd1 & srcb;
      ALU_OR:   aluresult = in.rd1 | srcb;
      ALU_XOR:  aluresult = in.rd1 ^ srcb;
      ALU_SLT:  aluresult = {{(XLEN-1){1'b0}}, ($signed(in.rd1) < $signed(srcb))};
      ALU_SLTU: aluresult = {{(XLEN-1){1'b0}}, (in.rd1 < srcb)};
      ALU_SLL:  aluresult = in.rd1 << shamt;
      ALU_SRL:  aluresult = in.rd1 >> shamt;
      ALU_SRA:  aluresult = $unsigned($signed(in.rd1) >>> shamt);
      default:  aluresult = '0;
    endcase
  end

  assign zero     = (aluresult == '0);
  assign pcsrc    = in.valid & ~flush & ~stall & (in.jump | (in.branch & zero));
  assign pctarget = in.pc + in.immext;

  ex_mem_t alu_next;

  always_comb begin
    alu_next = EX_MEM_BUBBLE;
    if (in.valid && !flush) begin
      alu_next.aluresult = aluresult;
      alu_next.writedata = in.rd2;
      alu_next.rd        = in.rd;
      alu_next.pcplus4   = in.pcplus4;
      alu_next.regwrite  = in.regwrite;
      alu_next.resultsrc = in.resultsrc;
      alu_next.memwrite  = in.memwrite;
    end
  end

`ifdef RISCV_EX_DIV_EN
  logic            div_start, div_idle, div_done, div_stall;
  logic [XLEN-1:0] div_result;
  ex_mem_t         div_hold, div_out;

  assign div_start = in.valid & ~flush & is_div_op(in.alucontrol);

  ex_divider #(
    .XLEN       (XLEN),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .flush    (flush),
    .op       (in.alucontrol),
    .dividend (in.rd1),
    .divisor  (in.rd2),
    .stall    (div_stall),
    .idle     (div_idle),
    .done     (div_done),
    .result   (div_result)
  );

  assign stall = div_stall;

  // Writeback fields of the divide, held while the divider runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_hold <= EX_MEM_BUBBLE;
    end else if (div_idle && div_start) begin
      div_hold           <= EX_MEM_BUBBLE;
      div_hold.rd        <= in.rd;
      div_hold.pcplus4   <= in.pcplus4;
      div_hold.regwrite  <= in.regwrite;
      div_hold.resultsrc <= in.resultsrc;
    end
  end

  always_comb begin
    div_out           = div_hold;
    div_out.aluresult = div_result;
  end

  always_ff @(posedge clk) begin
    if (rst)                      out <= EX_MEM_BUBBLE;
    else if (div_done)            out <= flush ? EX_MEM_BUBBLE : div_out;
    else if (!div_idle || div_start) out <= EX_MEM_BUBBLE;
    else                          out <= alu_next;
  end
`else
  assign stall = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) out <= EX_MEM_BUBBLE;
    else     out <= alu_next;
  end
`endif

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  id_ex_t      din;
  ex_mem_t     dout;
  logic        stall, pcsrc;
  logic [31:0] pctarget;

  int n_tests = 0;
  int n_fail  = 0;
  ex_mem_t exp_q[$];

  ex_stage #(.XLEN(32), .DIV_CYCLES(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (din),
    .flush    (flush),
    .out      (dout),
    .stall    (stall),
    .pcsrc    (pcsrc),
    .pctarget (pctarget)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic id_ex_t mk(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic alusrc, input logic [4:0] rd);
    id_ex_t x;
    x            = '0;
    x.valid      = 1'b1;
    x.rd1        = a;
    x.rd2        = b;
    x.immext     = imm;
    x.alusrc     = alusrc;
    x.rd         = rd;
    x.alucontrol = op;
    x.regwrite   = 1'b1;
    x.resultsrc  = RES_ALU;
    x.pc         = 32'h0000_2000 + {25'd0, rd, 2'b00};
    x.pcplus4    = x.pc + 32'd4;
    return x;
  endfunction

  function automatic logic [31:0] ref_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return sa >>> b[4:0];
`ifdef RISCV_EX_DIV_EN
      ALU_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : sa / sb;
      ALU_REM:  return (b == 0) ? a : ovf ? 32'd0 : sa % sb;
      ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 0) ? a : a % b;
`endif
      default:  return 32'd0;
    endcase
  endfunction

  function automatic ex_mem_t expect_of(input id_ex_t x);
    ex_mem_t e;
    logic [31:0] b;
    e = '0;
    if (!x.valid) return e;
    b           = x.alusrc ? x.immext : x.rd2;
    e.aluresult = ref_alu(x.alucontrol, x.rd1, b);
    e.writedata = x.rd2;
    e.rd        = x.rd;
    e.pcplus4   = x.pcplus4;
    e.regwrite  = x.regwrite;
    e.resultsrc = x.resultsrc;
    e.memwrite  = x.memwrite;
`ifdef RISCV_EX_DIV_EN
    if (is_div_op(x.alucontrol)) begin
      e.writedata = '0;
      e.memwrite  = 1'b0;
    end
`endif
    return e;
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    flush = 1'b0;
    din   = mk(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd1);
    tick();
    tick();
    din = '0;
    #1;
    n_tests++;
    if (dout !== EX_MEM_BUBBLE) begin
      n_fail++; $display("FAIL reset_out: got %h want %h", dout, EX_MEM_BUBBLE);
    end
    n_tests++;
    if (stall !== 1'b0 || pcsrc !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: stall=%b pcsrc=%b want 0 0", stall, pcsrc);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    alu_op_e     ops[10] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                             ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA};
    logic [31:0] av[4] = '{32'd5, 32'hFFFF_FFF0, 32'h8000_0001, 32'h1234_5678};
    logic [31:0] bv[4] = '{32'd7, 32'd3, 32'hFFFF_FFFF, 32'd33};
    ex_mem_t e;
    // ADD rd1=5 + imm 7 into x3
    din = mk(ALU_ADD, 32'd5, 32'd0, 32'd7, 1'b1, 5'd3);
    exp_q.push_back(expect_of(din));
    #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL add_stall: got %b want 0", stall); end
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (dout.aluresult !== 32'd12 || dout.rd !== 5'd3 || dout.regwrite !== 1'b1 || dout !== e) begin
      n_fail++; $display("FAIL add_imm: got %h want %h", dout, e);
    end
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++) begin
        din = mk(ops[i], av[j], bv[j], 32'h0, 1'b0, 5'(i + j + 1));
        exp_q.push_back(expect_of(din));
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (dout !== e) begin
          n_fail++; $display("FAIL alu_op%0d_v%0d: got %h want %h", i, j, dout, e);
        end
        din = '0;
        tick();
        n_tests++;
        if (dout.regwrite !== 1'b0 || dout.memwrite !== 1'b0) begin
          n_fail++; $display("FAIL alu_bubble%0d_%0d: regwrite=%b memwrite=%b want 0 0", i, j, dout.regwrite, dout.memwrite);
        end
      end
    end
  endtask

  task automatic test_store();
    ex_mem_t e;
    din          = mk(ALU_ADD, 32'h0000_1000, 32'hCAFE_F00D, 32'h0000_0010, 1'b1, 5'd0);
    din.regwrite = 1'b0;
    din.memwrite = 1'b1;
    exp_q.push_back(expect_of(din));
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (dout !== e || dout.writedata !== 32'hCAFE_F00D || dout.aluresult !== 32'h0000_1010) begin
      n_fail++; $display("FAIL store: got %h want %h", dout, e);
    end
    din = '0;
  endtask

  task automatic test_branch();
    din        = mk(ALU_SUB, 32'd9, 32'd9, 32'h20, 1'b0, 5'd0);
    din.pc     = 32'h100;
    din.branch = 1'b1;
    din.regwrite = 1'b0;
    #1;
    n_tests++;
    if (pcsrc !== 1'b1 || pctarget !== 32'h120) begin
      n_fail++; $display("FAIL beq_taken: pcsrc=%b tgt=%h want 1 00000120", pcsrc, pctarget);
    end
    flush = 1'b1;
    #1;
    n_tests++;
    if (pcsrc !== 1'b0) begin n_fail++; $display("FAIL beq_flush: pcsrc=%b want 0", pcsrc); end
    tick();
    flush = 1'b0;
    din.rd2 = 32'd8;
    #1;
    n_tests++;
    if (pcsrc !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken: pcsrc=%b want 0", pcsrc); end
    // JAL: redirect and link, then the same JAL squashed
    din         = mk(ALU_ADD, 32'd1, 32'd1, 32'h0000_0400, 1'b0, 5'd1);
    din.pc      = 32'h0000_0800;
    din.pcplus4 = 32'h0000_0804;
    din.jump    = 1'b1;
    din.resultsrc = RES_PC4;
    #1;
    n_tests++;
    if (pcsrc !== 1'b1 || pctarget !== 32'h0000_0C00) begin
      n_fail++; $display("FAIL jal: pcsrc=%b tgt=%h want 1 00000c00", pcsrc, pctarget);
    end
    tick();
    n_tests++;
    if (dout.regwrite !== 1'b1 || dout.pcplus4 !== 32'h0000_0804 || dout.resultsrc !== RES_PC4) begin
      n_fail++; $display("FAIL jal_out: got %h", dout);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (dout.regwrite !== 1'b0 || dout.memwrite !== 1'b0) begin
      n_fail++; $display("FAIL flush_bubble: regwrite=%b memwrite=%b want 0 0", dout.regwrite, dout.memwrite);
    end
    din.valid = 1'b0;
    #1;
    n_tests++;
    if (pcsrc !== 1'b0) begin n_fail++; $display("FAIL invalid_pcsrc: pcsrc=%b want 0", pcsrc); end
    tick();
    n_tests++;
    if (dout.regwrite !== 1'b0) begin n_fail++; $display("FAIL invalid_bubble: regwrite=%b want 0", dout.regwrite); end
    din = '0;
  endtask

  task automatic test_back_to_back();
    alu_op_e ops[10] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                         ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA};
    ex_mem_t e;
    din = mk(ALU_ADD, $urandom, $urandom, $urandom, 1'b1, 5'd2);
    exp_q.push_back(expect_of(din));
    for (int k = 0; k < 24; k++) begin
      tick();
      din = mk(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 5'(k));
      exp_q.push_back(expect_of(din));
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++; $display("FAIL b2b_empty: scoreboard empty at %0d", k);
      end else begin
        e = exp_q.pop_front();
        n_tests++;
        if (dout !== e) begin n_fail++; $display("FAIL b2b_%0d: got %h want %h", k, dout, e); end
      end
    end
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (dout !== e) begin n_fail++; $display("FAIL b2b_last: got %h want %h", dout, e); end
    din = '0;
  endtask

`ifdef RISCV_EX_DIV_EN
  task automatic test_div();
    alu_op_e     ops[12] = '{ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU, ALU_DIV, ALU_REM,
                             ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU, ALU_DIV, ALU_REMU};
    logic [31:0] av[12]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000,
                             32'd7, 32'd7, 32'd100, 32'd100, 32'hFFFF_FFF9, 32'hDEAD_BEEF};
    logic [31:0] bv[12]  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd7, 32'd7, 32'd0, 32'h0000_1357};
    ex_mem_t e;
    int      stall_cnt, lat;
    logic    found, adv;
    for (int k = 0; k < 12; k++) begin
      din = mk(ops[k], av[k], bv[k], 32'h0, 1'b0, 5'(k + 4));
      exp_q.push_back(expect_of(din));
      stall_cnt = 0;
      lat       = 0;
      found     = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
        #1;
        adv = !stall;
        if (stall) stall_cnt++;
        tick();
        if (adv) din = '0;
        if (dout.regwrite) begin
          found = 1'b1;
          lat   = c + 1;
        end
      end
      e = exp_q.pop_front();
      n_tests++;
      if (!found) begin
        n_fail++; $display("FAIL div%0d_timeout: no writeback within 60 cycles, want one", k);
      end else if (dout !== e) begin
        n_fail++; $display("FAIL div%0d_result: got %h want %h", k, dout, e);
      end
      n_tests++;
      if (lat != 34 || stall_cnt != 33) begin
        n_fail++; $display("FAIL div%0d_timing: latency=%0d stall_cycles=%0d want 34 33", k, lat, stall_cnt);
      end
      din = '0;
    end
  endtask

  task automatic test_div_flush();
    ex_mem_t e;
    logic    wr;
    din = mk(ALU_DIV, 32'd100, 32'd3, 32'h0, 1'b0, 5'd9);
    #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL dflush_issue_stall: got %b want 1", stall); end
    for (int c = 0; c < 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    din   = '0;
    #1;
    n_tests++;
    if (stall !== 1'b0 || dout.regwrite !== 1'b0) begin
      n_fail++; $display("FAIL dflush_drop: stall=%b regwrite=%b want 0 0", stall, dout.regwrite);
    end
    wr = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (dout.regwrite) wr = 1'b1;
    end
    n_tests++;
    if (wr !== 1'b0) begin n_fail++; $display("FAIL dflush_no_wb: writeback=%b want 0", wr); end
    din = mk(ALU_ADD, 32'd5, 32'd0, 32'd7, 1'b1, 5'd3);
    exp_q.push_back(expect_of(din));
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (dout !== e) begin n_fail++; $display("FAIL dflush_next_add: got %h want %h", dout, e); end
    din = '0;
  endtask

  task automatic test_div_reset();
    logic wr;
    din = mk(ALU_DIVU, 32'd1000, 32'd10, 32'h0, 1'b0, 5'd11);
    for (int c = 0; c < 6; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din = '0;
    #1;
    n_tests++;
    if (dout !== EX_MEM_BUBBLE || stall !== 1'b0) begin
      n_fail++; $display("FAIL drst: out=%h stall=%b want 0 0", dout, stall);
    end
    wr = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (dout.regwrite) wr = 1'b1;
    end
    n_tests++;
    if (wr !== 1'b0) begin n_fail++; $display("FAIL drst_no_wb: writeback=%b want 0", wr); end
  endtask
`else
  task automatic test_div_disabled();
    alu_op_e ops[4] = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    ex_mem_t e;
    for (int k = 0; k < 4; k++) begin
      din = mk(ops[k], 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0, 5'(k + 20));
      exp_q.push_back(expect_of(din));
      #1;
      n_tests++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL nodiv%0d_stall: got %b want 0", k, stall); end
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (dout !== e || dout.aluresult !== 32'd0 || dout.regwrite !== 1'b1) begin
        n_fail++; $display("FAIL nodiv%0d_out: got %h want %h", k, dout, e);
      end
    end
    din = '0;
  endtask
`endif

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    din   = '0;
    test_reset();
    test_alu();
    test_store();
    test_branch();
    test_back_to_back();
`ifdef RISCV_EX_DIV_EN
    test_div();
    test_div_flush();
    test_div_reset();
`else
    test_div_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
